// File: rtl/memory_stage_if.sv
// Execute-to-Memory bundle for memory_stage.
// slave : the memory stage (consumes E-stage fields, produces M-stage fields).
// master: the driver side (Execute stage / test harness).
// Ports  E side: RegWriteE, ResultSrcE, MemWriteE, Funct3E, ALUResultE,
//                WriteDataE, RdE, PCPlus4E
//        M side: RegWriteM, ResultSrcM, RdM, ALUResultM, PCPlus4M,
//                ReadDataM, MisalignedM
interface memory_stage_if #(
   parameter int unsigned WIDTH = 32
);
   // Execute-stage control and data
   logic             RegWriteE;
   logic [1:0]       ResultSrcE;
   logic             MemWriteE;
   logic [2:0]       Funct3E;
   logic [WIDTH-1:0] ALUResultE;
   logic [WIDTH-1:0] WriteDataE;
   logic [4:0]       RdE;
   logic [WIDTH-1:0] PCPlus4E;

   // Memory-stage results toward Writeback
   logic             RegWriteM;
   logic [1:0]       ResultSrcM;
   logic [4:0]       RdM;
   logic [WIDTH-1:0] ALUResultM;
   logic [WIDTH-1:0] PCPlus4M;
   logic [WIDTH-1:0] ReadDataM;
   logic             MisalignedM;

   modport master (
      output RegWriteE, ResultSrcE, MemWriteE, Funct3E,
             ALUResultE, WriteDataE, RdE, PCPlus4E,
      input  RegWriteM, ResultSrcM, RdM, ALUResultM, PCPlus4M,
             ReadDataM, MisalignedM
   );

   modport slave (
      input  RegWriteE, ResultSrcE, MemWriteE, Funct3E,
             ALUResultE, WriteDataE, RdE, PCPlus4E,
      output RegWriteM, ResultSrcM, RdM, ALUResultM, PCPlus4M,
             ReadDataM, MisalignedM
   );
endinterface

// File: rtl/memory_stage.sv
// Pipeline Memory stage: E/M register, byte-addressed little-endian data RAM,
// load extension, store byte-enables and misalignment detection.
// Ports: clk    - clock, rising edge
//        rst    - synchronous active-high reset of the M register (RAM kept)
//        StallM - hold the M register and suppress the store in M
//        FlushM - load a bubble into the M register
//        bus    - memory_stage_if.slave (E-stage inputs, M-stage outputs)
module memory_stage #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned ADDR_WIDTH = 12
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           StallM,
   input  logic           FlushM,
   memory_stage_if.slave  bus
);
   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // E/M pipeline register
   logic             reg_write_q;
   logic [1:0]       result_src_q;
   logic             mem_write_q;
   logic [2:0]       funct3_q;
   logic [WIDTH-1:0] alu_result_q;
   logic [WIDTH-1:0] write_data_q;
   logic [4:0]       rd_q;
   logic [WIDTH-1:0] pc_plus4_q;

   logic [7:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
   logic [7:0]            b0, b1, b2, b3;
   logic                  misaligned;
   logic [WIDTH-1:0]      read_data;
   logic                  store_en;

   // Pipeline register: rst > FlushM > StallM > capture
   always_ff @(posedge clk) begin
      if (rst || FlushM) begin
         reg_write_q  <= 1'b0;
         result_src_q <= 2'b00;
         mem_write_q  <= 1'b0;
         funct3_q     <= 3'b000;
         alu_result_q <= '0;
         write_data_q <= '0;
         rd_q         <= 5'd0;
         pc_plus4_q   <= '0;
      end else if (!StallM) begin
         reg_write_q  <= bus.RegWriteE;
         result_src_q <= bus.ResultSrcE;
         mem_write_q  <= bus.MemWriteE;
         funct3_q     <= bus.Funct3E;
         alu_result_q <= bus.ALUResultE;
         write_data_q <= bus.WriteDataE;
         rd_q         <= bus.RdE;
         pc_plus4_q   <= bus.PCPlus4E;
      end
   end

   // Byte lanes; upper address bits are dropped so accesses wrap in the RAM
   always_comb begin
      a0 = alu_result_q[ADDR_WIDTH-1:0];
      a1 = a0 + ADDR_WIDTH'(1);
      a2 = a0 + ADDR_WIDTH'(2);
      a3 = a0 + ADDR_WIDTH'(3);
      b0 = mem[a0];
      b1 = mem[a1];
      b2 = mem[a2];
      b3 = mem[a3];
   end

   // Alignment check depends only on the access width encoding
   always_comb begin
      misaligned = 1'b0;
      case (funct3_q)
         F3_H, F3_HU: misaligned = a0[0];
         F3_W:        misaligned = |a0[1:0];
         default:     misaligned = 1'b0;
      endcase
   end

   // Load extension; misaligned or undefined encodings read as zero
   always_comb begin
      read_data = '0;
      case (funct3_q)
         F3_B:    read_data = {{(WIDTH-8){b0[7]}}, b0};
         F3_H:    read_data = {{(WIDTH-16){b1[7]}}, b1, b0};
         F3_W:    read_data = WIDTH'({b3, b2, b1, b0});
         F3_BU:   read_data = WIDTH'(b0);
         F3_HU:   read_data = WIDTH'({b1, b0});
         default: read_data = '0;
      endcase
      if (misaligned) read_data = '0;
   end

   // A store leaves M exactly once: at the first unstalled, non-reset edge
   assign store_en = mem_write_q && !misaligned && !StallM && !rst;

   // Data RAM write port; contents are never reset
   always_ff @(posedge clk) begin
      if (store_en) begin
         case (funct3_q)
            F3_B: mem[a0] <= write_data_q[7:0];
            F3_H: begin
               mem[a0] <= write_data_q[7:0];
               mem[a1] <= write_data_q[15:8];
            end
            F3_W: begin
               mem[a0] <= write_data_q[7:0];
               mem[a1] <= write_data_q[15:8];
               mem[a2] <= write_data_q[23:16];
               mem[a3] <= write_data_q[31:24];
            end
            default: ;
         endcase
      end
   end

   assign bus.RegWriteM   = reg_write_q;
   assign bus.ResultSrcM  = result_src_q;
   assign bus.RdM         = rd_q;
   assign bus.ALUResultM  = alu_result_q;
   assign bus.PCPlus4M    = pc_plus4_q;
   assign bus.ReadDataM   = read_data;
   assign bus.MisalignedM = misaligned;
endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: a table of single-cycle instructions
// streamed through E with results checked while each sits in M, followed by
// hand-written stall, flush and reset sequences.
module tb_memory_stage;
   logic clk = 1'b0;
   logic rst;
   logic stall;
   logic flush;

   int n_tests = 0;
   int n_fail  = 0;

   memory_stage_if #(.WIDTH(32)) bus ();

   memory_stage #(.WIDTH(32), .ADDR_WIDTH(12)) dut (
      .clk    (clk),
      .rst    (rst),
      .StallM (stall),
      .FlushM (flush),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [4:0]  rd;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic        exp_mis;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   function automatic vec_t mk(string name, logic we, logic [2:0] f3, logic [31:0] addr,
                               logic [31:0] wd, logic [4:0] rd, logic chk_rd,
                               logic [31:0] exp_rd, logic exp_mis);
      vec_t v;
      v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd; v.rd = rd;
      v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_mis = exp_mis;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wd,
                        logic [4:0] rd);
      bus.MemWriteE  = we;
      bus.RegWriteE  = !we;
      bus.ResultSrcE = we ? 2'd0 : 2'd1;
      bus.Funct3E    = f3;
      bus.ALUResultE = addr;
      bus.WriteDataE = wd;
      bus.RdE        = rd;
      bus.PCPlus4E   = 32'h0000_1000 + 32'(rd);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Program: one instruction per cycle, checked while in M
      vecs[0]  = mk("sw_deadbeef",  1, 3'b010, 32'h010, 32'hDEADBEEF, 5'd0,  0, 32'h0,        0);
      vecs[1]  = mk("lw_010",       0, 3'b010, 32'h010, 32'h0,        5'd1,  1, 32'hDEADBEEF, 0);
      vecs[2]  = mk("sw_11223344",  1, 3'b010, 32'h020, 32'h11223344, 5'd0,  0, 32'h0,        0);
      vecs[3]  = mk("sb_021_old",   1, 3'b000, 32'h021, 32'h00000080, 5'd0,  1, 32'h00000033, 0);
      vecs[4]  = mk("lb_021",       0, 3'b000, 32'h021, 32'h0,        5'd2,  1, 32'hFFFFFF80, 0);
      vecs[5]  = mk("lbu_021",      0, 3'b100, 32'h021, 32'h0,        5'd3,  1, 32'h00000080, 0);
      vecs[6]  = mk("lw_020",       0, 3'b010, 32'h020, 32'h0,        5'd4,  1, 32'h11228044, 0);
      vecs[7]  = mk("lh_020",       0, 3'b001, 32'h020, 32'h0,        5'd5,  1, 32'hFFFF8044, 0);
      vecs[8]  = mk("lhu_022",      0, 3'b101, 32'h022, 32'h0,        5'd6,  1, 32'h00001122, 0);
      vecs[9]  = mk("sh_013_mis",   1, 3'b001, 32'h013, 32'h00005555, 5'd0,  1, 32'h0,        1);
      vecs[10] = mk("lw_010_keep",  0, 3'b010, 32'h010, 32'h0,        5'd7,  1, 32'hDEADBEEF, 0);
      vecs[11] = mk("lw_012_mis",   0, 3'b010, 32'h012, 32'h0,        5'd8,  1, 32'h0,        1);
      vecs[12] = mk("ld_f3_011",    0, 3'b011, 32'h010, 32'h0,        5'd9,  1, 32'h0,        0);
      vecs[13] = mk("sw_1004_wrap", 1, 3'b010, 32'h1004, 32'hCAFEF00D, 5'd0, 0, 32'h0,        0);
      vecs[14] = mk("lw_004_wrap",  0, 3'b010, 32'h004, 32'h0,        5'd10, 1, 32'hCAFEF00D, 0);
      vecs[15] = mk("st_f3_110",    1, 3'b110, 32'h010, 32'hFFFFFFFF, 5'd0,  1, 32'h0,        0);
      vecs[16] = mk("lw_010_nost",  0, 3'b010, 32'h010, 32'h0,        5'd11, 1, 32'hDEADBEEF, 0);
      vecs[17] = mk("lhu_011_mis",  0, 3'b101, 32'h011, 32'h0,        5'd12, 1, 32'h0,        1);
      vecs[18] = mk("lh_012",       0, 3'b001, 32'h012, 32'h0,        5'd13, 1, 32'hFFFFDEAD, 0);

      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      drive(1'b1, 3'b010, 32'h0000_0abc, 32'h1234_5678, 5'd31);
      tick(); tick();

      // Reset state of the M register
      chk("rst_regwrite",  32'(bus.RegWriteM),  32'h0);
      chk("rst_resultsrc", 32'(bus.ResultSrcM), 32'h0);
      chk("rst_rd",        32'(bus.RdM),        32'h0);
      chk("rst_aluresult", bus.ALUResultM,      32'h0);
      chk("rst_pcplus4",   bus.PCPlus4M,        32'h0);
      chk("rst_misalign",  32'(bus.MisalignedM), 32'h0);

      rst = 1'b0;
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, vecs[i].rd);
         tick();
         chk({vecs[i].name, "_mis"}, 32'(bus.MisalignedM), 32'(vecs[i].exp_mis));
         chk({vecs[i].name, "_alu"}, bus.ALUResultM, vecs[i].addr);
         chk({vecs[i].name, "_regwr"}, 32'(bus.RegWriteM), 32'(!vecs[i].we));
         chk({vecs[i].name, "_rdm"}, 32'(bus.RdM), 32'(vecs[i].rd));
         if (vecs[i].chk_rd)
            chk({vecs[i].name, "_data"}, bus.ReadDataM, vecs[i].exp_rd);
      end

      // Stall with a store in M: frozen outputs, write only after release
      drive(1'b1, 3'b010, 32'h030, 32'hAAAAAAAA, 5'd0);
      tick();
      drive(1'b1, 3'b010, 32'h030, 32'h01020304, 5'd0);
      tick();
      chk("stall_pre_data", bus.ReadDataM, 32'hAAAAAAAA);
      stall = 1'b1;
      drive(1'b0, 3'b010, 32'h030, 32'h0, 5'd14);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("stall_data",    bus.ReadDataM, 32'hAAAAAAAA);
         chk("stall_alu",     bus.ALUResultM, 32'h030);
         chk("stall_regwr",   32'(bus.RegWriteM), 32'h0);
         chk("stall_pcplus4", bus.PCPlus4M, 32'h0000_1000);
      end
      stall = 1'b0;
      tick();
      chk("unstall_data",  bus.ReadDataM, 32'h01020304);
      chk("unstall_rd",    32'(bus.RdM), 32'd14);

      // Flush with a store in E: bubble in M, RAM untouched
      flush = 1'b1;
      drive(1'b1, 3'b010, 32'h030, 32'h77777777, 5'd0);
      tick();
      chk("flush_regwr", 32'(bus.RegWriteM), 32'h0);
      chk("flush_alu",   bus.ALUResultM, 32'h0);
      chk("flush_pc",    bus.PCPlus4M, 32'h0);
      flush = 1'b0;
      drive(1'b0, 3'b010, 32'h030, 32'h0, 5'd15);
      tick();
      chk("flush_nowrite", bus.ReadDataM, 32'h01020304);

      // Reset (with stall also high) drops a pending store; RAM kept
      drive(1'b1, 3'b000, 32'h000, 32'h0000009A, 5'd0);
      tick();
      drive(1'b1, 3'b010, 32'h000, 32'h5A5A5A5A, 5'd0);
      tick();
      rst = 1'b1; stall = 1'b1;
      drive(1'b0, 3'b010, 32'h040, 32'h0, 5'd16);
      tick();
      chk("rst2_alu",     bus.ALUResultM, 32'h0);
      chk("rst2_rd",      32'(bus.RdM), 32'h0);
      chk("rst2_mis",     32'(bus.MisalignedM), 32'h0);
      chk("rst2_byte0",   bus.ReadDataM, 32'hFFFFFF9A);
      rst = 1'b0; stall = 1'b0;
      drive(1'b0, 3'b100, 32'h000, 32'h0, 5'd17);
      tick();
      chk("rst2_lbu0",    bus.ReadDataM, 32'h0000009A);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
